// File: rtl/sc_acc_array_if.sv
// -----------------------------------------------------------------------------
// sc_acc_array_if
// Bus between the stochastic bit source and the sc_acc_array accumulator.
//   iStart : request to begin one accumulation window
//   iBit   : ADIM stochastic bits per lane, one entry per lane
//   oData  : last completed window count per lane (offset-binary)
//   oValid : one-cycle pulse when oData takes a new window result
//   oBusy  : high while a window is in progress
// Modports: master = bit source / consumer, slave = accumulator.
// -----------------------------------------------------------------------------
interface sc_acc_array_if #(
    parameter int IDIM = 4,
    parameter int ADIM = 32,
    parameter int IWID = 16
) ();
    logic            iStart;
    logic [ADIM-1:0] iBit  [IDIM];
    logic [IWID-1:0] oData [IDIM];
    logic            oValid;
    logic            oBusy;

    modport master (
        output iStart,
        output iBit,
        input  oData,
        input  oValid,
        input  oBusy
    );

    modport slave (
        input  iStart,
        input  iBit,
        output oData,
        output oValid,
        output oBusy
    );
endinterface

// File: rtl/sc_acc_array.sv
// -----------------------------------------------------------------------------
// sc_acc_array
// IDIM independent stochastic-computing accumulators. Each lane sums the
// popcount of its ADIM-bit input over a window of exactly 2**OWID consecutive
// cycles; the window total is published on oData with a one-cycle oValid pulse.
// The total is offset-binary around ADIM*2**OWID/2 and is consumed unchanged
// by the downstream activation stage.
//
// Ports:
//   clk     : single clock, rising edge
//   rst     : synchronous, active-high reset (priority over iStart)
//   bus     : sc_acc_array_if.slave (iStart, iBit, oData, oValid, oBusy)
//   o_state : current FSM state (0 = IDLE, 1 = ACCUM) for observation
//
// Handshake: iStart is sampled only in IDLE; the start cycle is sample 0.
// iStart seen during ACCUM is dropped, never queued. oValid rises in the cycle
// after the final sample; iStart in that cycle starts the next window with no
// gap. oData only changes at window completion or reset, so it never shows a
// partial sum.
// -----------------------------------------------------------------------------
module sc_acc_array #(
    parameter int IDIM = 4,
    parameter int ADIM = 32,
    parameter int OWID = 8,
    parameter int IWID = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    sc_acc_array_if.slave         bus,
    output logic                  o_state
);
    localparam int PW = $clog2(ADIM + 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ACCUM = 1'b1;

    localparam logic [OWID-1:0] CNT_LAST = {OWID{1'b1}};
    localparam logic [OWID-1:0] CNT_ONE  = OWID'(1);

    // The full-window total must fit the accumulator width.
    generate
        if (IWID < $clog2(ADIM * (2 ** OWID) + 1)) begin : g_width_check
            $error("sc_acc_array: IWID too small for ADIM*2**OWID");
        end
    endgenerate

    logic [0:0]      r_state;
    logic [OWID-1:0] r_cnt;
    logic [IWID-1:0] r_acc  [IDIM];
    logic [IWID-1:0] r_data [IDIM];
    logic            r_valid;
    logic [PW-1:0]   w_pop  [IDIM];

    function automatic logic [PW-1:0] popcnt(input logic [ADIM-1:0] v);
        logic [PW-1:0] s;
        s = '0;
        for (int j = 0; j < ADIM; j++) begin
            s = s + PW'(v[j]);
        end
        return s;
    endfunction

    always_comb begin
        for (int i = 0; i < IDIM; i++) begin
            w_pop[i] = popcnt(bus.iBit[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            for (int i = 0; i < IDIM; i++) begin
                r_acc[i]  <= '0;
                r_data[i] <= '0;
            end
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.iStart) begin
                        // Start cycle contributes sample 0.
                        r_state <= S_ACCUM;
                        r_cnt   <= CNT_ONE;
                        for (int i = 0; i < IDIM; i++) begin
                            r_acc[i] <= IWID'(w_pop[i]);
                        end
                    end
                end
                S_ACCUM: begin
                    if (r_cnt == CNT_LAST) begin
                        // Final sample goes straight into the published total.
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_valid <= 1'b1;
                        for (int i = 0; i < IDIM; i++) begin
                            r_data[i] <= r_acc[i] + IWID'(w_pop[i]);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                        for (int i = 0; i < IDIM; i++) begin
                            r_acc[i] <= r_acc[i] + IWID'(w_pop[i]);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.oData  = r_data;
    assign bus.oValid = r_valid;
    assign bus.oBusy  = (r_state == S_ACCUM);
    assign o_state    = r_state;

endmodule

// File: doc/sc_acc_array.md
SC_ACC_ARRAY -- requirements
Module: sc_acc_array

Interface
REQ-001 Parameter IDIM, default 4: number of independent accumulation lanes.
REQ-002 Parameter ADIM, default 32: stochastic bits per lane per cycle (accumulation depth).
REQ-003 Parameter OWID, default 8: window length is 2**OWID cycles.
REQ-004 Parameter IWID, default 16: accumulator/output width; SHALL satisfy IWID >= clog2(ADIM*2**OWID + 1), checked by elaboration-time assertion.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 iStart  input  1  request to begin one accumulation window.
REQ-008 iBit  input  [ADIM-1:0] x [IDIM-1:0] (unpacked over lanes)  stochastic bits per lane.
REQ-009 oData  output  [IWID-1:0] x [IDIM-1:0] (unpacked over lanes)  completed window count per lane, offset-binary, midpoint ADIM*2**OWID/2, directly consumable by downstream activation stage.
REQ-010 oValid  output  1  one-cycle pulse: oData updated with a new window result.
REQ-011 oBusy  output  1  high while a window is in progress.

Function
REQ-012 FSM SHALL have two states: IDLE, ACCUM.
REQ-013 IDLE: iStart=1 at an edge -> ACCUM; window counter cnt <= 1; lane accumulators acc[i] <= popcount(iBit[i]) (start cycle is sample 0).
REQ-014 IDLE with iStart=0: state, acc, cnt, oData unchanged.
REQ-015 ACCUM, cnt < 2**OWID-1: acc[i] <= acc[i] + popcount(iBit[i]); cnt <= cnt+1.
REQ-016 ACCUM, cnt == 2**OWID-1 (final sample): oData[i] <= acc[i] + popcount(iBit[i]); oValid <= 1; state -> IDLE; cnt <= 0.
REQ-017 Window SHALL sample exactly 2**OWID consecutive cycles of iBit; oValid asserts in the cycle after the last sample (latency 2**OWID cycles from iStart cycle to oValid cycle).
REQ-018 oValid SHALL be high for exactly one cycle per window; zero otherwise.
REQ-019 oData SHALL hold its last value until the next window completes; it SHALL never show partial sums.
REQ-020 popcount width clog2(ADIM+1); sums SHALL be unsigned, zero-extended to IWID; no saturation needed (REQ-004 guarantees no overflow); max value ADIM*2**OWID.
REQ-021 iStart asserted while in ACCUM (including final cycle) SHALL be ignored, not queued.
REQ-022 iStart asserted in the oValid cycle (state IDLE) SHALL start a new window immediately; back-to-back windows have no gap cycles.
REQ-023 oBusy = (state == ACCUM), combinational from state register.
REQ-024 Lanes SHALL be fully independent; lane i result depends only on iBit[i].

Reset
REQ-025 rst=1 at an edge: state <= IDLE, cnt <= 0, acc[i] <= 0, oData[i] <= 0, oValid <= 0; rst has priority over iStart.
REQ-026 rst mid-window SHALL abort the window with no oValid pulse; first window after reset needs a fresh iStart.

Verification
REQ-027 Defaults, iStart 1 cycle, iBit all ones all lanes for 256 cycles -> oValid single pulse at cycle 256 after start, oData = 8192 every lane.
REQ-028 iBit all zeros -> oData = 0; then lane 0 bits alternate 0x0000FFFF/0xFFFF0000, lane 1 = 0xFFFFFFFF, lanes 2,3 = 0 -> oData = {4096, 8192, 0, 0}.
REQ-029 iStart pulsed again at cycles 10 and 255 of a window -> ignored; exactly one oValid, at cycle 256.
REQ-030 iStart held high continuously for 3 windows -> oValid at cycles 256, 512, 768; oBusy low only in the oValid cycles; each oData matches its own window.
REQ-031 rst asserted at cycle 100 of a window -> next cycle oData = 0, oValid = 0, oBusy = 0; no oValid until a new iStart plus 256 cycles.
REQ-032 Random iBit, random iStart, all lanes -> oData per lane equals scoreboard sum of popcounts over the exact 256 sampled cycles.
